// File: rtl/serial_tx.sv
// Serial transmitter: start bit, DATA_W data bits LSB first, optional even parity, stop bit.
// Every line bit is held CLKS_PER_BIT clocks; tx and done are registered from the next state.
module serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid,
    output logic              ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int              CNT_W   = 16;
    localparam int              IDX_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic               par_q, par_d;
    logic               tx_q, tx_d;
    logic               done_q, done_d;
    logic               bit_last;

    function automatic logic even_parity(input logic [DATA_W-1:0] w);
        return ^w;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign bit_last = (cnt_q == CNT_MAX);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        if (state_q == IDLE) begin
            if (valid) begin
                state_d = START;
                cnt_d   = '0;
                idx_d   = '0;
                shift_d = data_in;
                par_d   = even_parity(data_in);
            end
        end else begin
            cnt_d = bit_last ? '0 : cnt_q + CNT_W'(1);
            if (bit_last) begin
                unique case (state_q)
                    START:   state_d = DATA;
                    DATA: begin
                        // Shifting exposes the next data bit on shift_d[0].
                        shift_d = shift_q >> 1;
                        if (idx_q == IDX_MAX) begin
                            idx_d   = '0;
                            state_d = (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                    PARITY:  state_d = STOP;
                    STOP:    state_d = IDLE;
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // Output logic, computed from the next state so the registered outputs line up
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_d;
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
        done_d = (state_d == STOP) && (cnt_d == CNT_MAX);
    end

    assign ready = (state_q == IDLE);
    assign busy  = ~ready;
    assign tx    = tx_q;
    assign done  = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: three instances (4 clk/bit, 4 clk/bit with parity, 1 clk/bit) checked
// every cycle against a frame-position model, plus directed frames with literal expectations.
module tb_serial_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din [3];
    logic [2:0] vld;
    logic [2:0] rdy_w, tx_w, busy_w, done_w;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Model: position inside the current frame (0 = idle) and the captured word
    int         pos  [3];
    logic [7:0] word [3];

    always #5 clk = ~clk;

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) u0 (
        .clk(clk), .reset(rst), .data_in(din[0]), .valid(vld[0]),
        .ready(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));
    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) u1 (
        .clk(clk), .reset(rst), .data_in(din[1]), .valid(vld[1]),
        .ready(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));
    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) u2 (
        .clk(clk), .reset(rst), .data_in(din[2]), .valid(vld[2]),
        .ready(rdy_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));

    function automatic int cpb(input int i);
        return (i == 2) ? 1 : 4;
    endfunction

    function automatic int par_en(input int i);
        return (i == 1) ? 1 : 0;
    endfunction

    function automatic int frame_len(input int i);
        return (8 + 2 + par_en(i)) * cpb(i);
    endfunction

    // Line level at a given frame position: bit number = (pos-1)/clocks-per-bit
    function automatic logic exp_tx(input int i, input int p, input logic [7:0] w);
        int b;
        if (p == 0) return 1'b1;
        b = (p - 1) / cpb(i);
        if (b == 0) return 1'b0;
        if (b <= 8) return w[b-1];
        if (par_en(i) != 0 && b == 9) return ^w;
        return 1'b1;
    endfunction

    task automatic check(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) pos[i] <= 0;
            else if (pos[i] == 0) begin
                if (vld[i]) begin
                    pos[i]  <= 1;
                    word[i] <= din[i];
                end
            end else if (pos[i] == frame_len(i)) pos[i] <= 0;
            else pos[i] <= pos[i] + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("u%0d.tx", i), tx_w[i], exp_tx(i, pos[i], word[i]));
                check($sformatf("u%0d.ready", i), rdy_w[i], pos[i] == 0);
                check($sformatf("u%0d.busy", i), busy_w[i], pos[i] != 0);
                check($sformatf("u%0d.done", i), done_w[i], pos[i] == frame_len(i));
            end
        end
    end

    // Offer one word, record the line from the cycle after acceptance through done.
    task automatic run_frame(input int i, input logic [7:0] d,
                             output logic [63:0] line, output int dcyc);
        int t;
        @(negedge clk);
        din[i] = d;
        vld[i] = 1'b1;
        for (t = 0; t < 200 && !rdy_w[i]; t++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        vld[i] = 1'b0;
        line = '0;
        dcyc = 0;
        for (int k = 1; k < 64; k++) begin
            line[k] = tx_w[i];
            if (done_w[i]) begin
                dcyc = k;
                break;
            end
            @(negedge clk);
        end
        if (dcyc == 0) check_int("frame_timeout", 0, 1);
    endtask

    initial begin
        logic [63:0] line;
        logic [9:0]  pat;
        int          dcyc;
        int          t;

        vld = '0;
        for (int i = 0; i < 3; i++) din[i] = 8'h00;
        repeat (3) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("reset_tx", tx_w[0], 1'b1);
        check("reset_ready", rdy_w[0], 1'b1);
        check("reset_busy", busy_w[0], 1'b0);
        check("reset_done", done_w[0], 1'b0);

        // 0xA5 at 4 clk/bit
        run_frame(0, 8'hA5, line, dcyc);
        pat = 10'b1101001010;
        for (int b = 0; b < 10; b++)
            for (int c = 0; c < 4; c++)
                check($sformatf("a5_bit%0d", b), line[1 + b*4 + c], pat[b]);
        check_int("a5_done_cycle", dcyc, 40);
        @(negedge clk);
        check("a5_ready_after", rdy_w[0], 1'b1);

        // Parity instance
        run_frame(1, 8'hA5, line, dcyc);
        check("par_a5", line[37], 1'b0);
        check_int("par_a5_len", dcyc, 44);
        run_frame(1, 8'h07, line, dcyc);
        check("par_07", line[37], 1'b1);
        check_int("par_07_len", dcyc, 44);

        // One clock per bit
        run_frame(2, 8'h81, line, dcyc);
        pat = 10'b1100000010;
        for (int b = 0; b < 10; b++) check($sformatf("x81_bit%0d", b), line[1 + b], pat[b]);
        check_int("x81_done_cycle", dcyc, 10);

        // Back-to-back with valid held high
        @(negedge clk);
        din[0] = 8'h3C;
        vld[0] = 1'b1;
        for (t = 0; t < 200 && !rdy_w[0]; t++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        din[0] = 8'hC3;
        for (t = 0; t < 100 && !done_w[0]; t++) @(negedge clk);
        check("b2b_first_done", done_w[0], 1'b1);
        @(negedge clk);
        check("b2b_idle_gap", rdy_w[0], 1'b1);
        @(negedge clk);
        check("b2b_second_accept", busy_w[0], 1'b1);
        check("b2b_second_start", tx_w[0], 1'b0);
        vld[0] = 1'b0;
        for (t = 0; t < 100 && !rdy_w[0]; t++) @(negedge clk);
        check("b2b_back_idle", rdy_w[0], 1'b1);

        // Reset during data bit 3 of 0xFF
        @(negedge clk);
        din[0] = 8'hFF;
        vld[0] = 1'b1;
        for (t = 0; t < 200 && !rdy_w[0]; t++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        vld[0] = 1'b0;
        repeat (16) @(negedge clk);
        check("abort_bit3_high", tx_w[0], 1'b1);
        check("abort_in_frame", busy_w[0], 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_tx", tx_w[0], 1'b1);
        check("abort_done", done_w[0], 1'b0);
        check("abort_ready", rdy_w[0], 1'b1);
        run_frame(0, 8'h00, line, dcyc);
        pat = 10'b1000000000;
        for (int b = 0; b < 10; b++) check($sformatf("x00_bit%0d", b), line[1 + b*4], pat[b]);
        check_int("x00_done_cycle", dcyc, 40);

        // Randomized traffic, including mid-frame valid/data churn and occasional resets
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                vld[i] = ($urandom_range(0, 3) == 0);
                din[i] = 8'($urandom);
            end
            rst = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        vld = '0;
        repeat (50) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
